// File: rtl/switch_box_pkg.sv
// ---------------------------------------------------------------------------
// switch_box_pkg
// Shared definitions for the configurable routing switch box:
//   - side codes stored in each routing entry
//   - configuration command opcodes
//   - FSM state type for the configuration controller
//   - helper for deriving the index field width
// No ports (package).
// ---------------------------------------------------------------------------
package switch_box_pkg;

    // Side code carried in entry[2:0]; 5..7 are never stored
    localparam logic [2:0] SIDE_OFF    = 3'd0;
    localparam logic [2:0] SIDE_TOP    = 3'd1;
    localparam logic [2:0] SIDE_RIGHT  = 3'd2;
    localparam logic [2:0] SIDE_BOTTOM = 3'd3;
    localparam logic [2:0] SIDE_LEFT   = 3'd4;

    // Configuration command opcodes
    localparam logic [1:0] OP_WRITE  = 2'd0;
    localparam logic [1:0] OP_COMMIT = 2'd1;
    localparam logic [1:0] OP_CLEAR  = 2'd2;
    localparam logic [1:0] OP_READ   = 2'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Width of the wire index field; at least one bit so degenerate
    // one-wire sides still produce a legal vector width.
    function automatic int idx_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sb_route_mux.sv
// ---------------------------------------------------------------------------
// sb_route_mux
// Selects the value driving one output wire of the switch box from any wire
// on any of the four input sides, as described by one routing entry.
// Ports:
//   entry     in   {idx, side} routing entry (active configuration)
//   in_top    in   W_TB top input wires
//   in_right  in   W_LR right input wires
//   in_bottom in   W_TB bottom input wires
//   in_left   in   W_LR left input wires
//   out       out  selected input value (0 when off)
//   oe        out  drive enable (1 whenever side is not off)
// ---------------------------------------------------------------------------
module sb_route_mux
    import switch_box_pkg::*;
#(
    parameter int W_TB  = 5,
    parameter int W_LR  = 4,
    parameter int IDX_W = 3
) (
    input  logic [IDX_W+2:0] entry,
    input  logic [W_TB-1:0]  in_top,
    input  logic [W_LR-1:0]  in_right,
    input  logic [W_TB-1:0]  in_bottom,
    input  logic [W_LR-1:0]  in_left,
    output logic             out,
    output logic             oe
);

    // Every side is zero-padded to the full index range so any idx value is
    // a legal bit select; the top level never stores an out-of-range index.
    localparam int PAD_W = 2 ** IDX_W;

    logic [2:0]       side;
    logic [IDX_W-1:0] idx;
    logic [PAD_W-1:0] top_pad;
    logic [PAD_W-1:0] right_pad;
    logic [PAD_W-1:0] bottom_pad;
    logic [PAD_W-1:0] left_pad;

    assign side       = entry[2:0];
    assign idx        = entry[IDX_W+2:3];
    assign top_pad    = PAD_W'(in_top);
    assign right_pad  = PAD_W'(in_right);
    assign bottom_pad = PAD_W'(in_bottom);
    assign left_pad   = PAD_W'(in_left);

    always_comb begin
        out = 1'b0;
        oe  = 1'b0;
        case (side)
            SIDE_TOP: begin
                out = top_pad[idx];
                oe  = 1'b1;
            end
            SIDE_RIGHT: begin
                out = right_pad[idx];
                oe  = 1'b1;
            end
            SIDE_BOTTOM: begin
                out = bottom_pad[idx];
                oe  = 1'b1;
            end
            SIDE_LEFT: begin
                out = left_pad[idx];
                oe  = 1'b1;
            end
            default: begin
                out = 1'b0;
                oe  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/switch_box_cfg.sv
// ---------------------------------------------------------------------------
// switch_box_cfg
// Parametrised routing switch box with double-buffered configuration.
// Every output wire on the four sides is driven by any input wire on any
// side, or left undriven. Entries are written into a shadow store through a
// valid/ready command port and copied to the active store by COMMIT, so the
// routing changes atomically.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_top/in_bottom   [W_TB]    input wires top/bottom
//   in_left/in_right   [W_LR]    input wires left/right
//   out_*/oe_*                   routed values and drive enables per side
//   cfg_valid/cfg_ready          command handshake
//   cfg_op                       0=WRITE 1=COMMIT 2=CLEAR 3=READ
//   cfg_addr                     output index: top, right, bottom, left
//   cfg_wdata                    entry {idx, side}
//   cfg_rdata/cfg_rvalid         READ result and one-cycle valid pulse
//   cfg_done                     one-cycle pulse after COMMIT or CLEAR
//   cfg_err                      one-cycle pulse for a rejected command
// ---------------------------------------------------------------------------
module switch_box_cfg
    import switch_box_pkg::*;
#(
    parameter int  W_TB    = 5,
    parameter int  W_LR    = 4,
    parameter bit  REG_OUT = 1'b0,
    localparam int IDX_W   = idx_width(W_TB, W_LR),
    localparam int N_OUT   = 2 * (W_TB + W_LR),
    localparam int ADDR_W  = $clog2(N_OUT),
    localparam int ENT_W   = 3 + IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W_TB-1:0]   in_top,
    input  logic [W_LR-1:0]   in_right,
    input  logic [W_TB-1:0]   in_bottom,
    input  logic [W_LR-1:0]   in_left,
    output logic [W_TB-1:0]   out_top,
    output logic [W_TB-1:0]   oe_top,
    output logic [W_LR-1:0]   out_right,
    output logic [W_LR-1:0]   oe_right,
    output logic [W_TB-1:0]   out_bottom,
    output logic [W_TB-1:0]   oe_bottom,
    output logic [W_LR-1:0]   out_left,
    output logic [W_LR-1:0]   oe_left,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_op,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [ENT_W-1:0]  cfg_wdata,
    output logic [ENT_W-1:0]  cfg_rdata,
    output logic              cfg_rvalid,
    output logic              cfg_done,
    output logic              cfg_err
);

    // Start offsets of each side inside the flat output numbering
    localparam int RIGHT0  = W_TB;
    localparam int BOTTOM0 = W_TB + W_LR;
    localparam int LEFT0   = 2 * W_TB + W_LR;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_OUT - 1);

    state_t            state;
    logic [ADDR_W-1:0] clr_addr;
    logic [ENT_W-1:0]  shadow [N_OUT];
    logic [ENT_W-1:0]  active [N_OUT];

    logic              accept;
    logic [2:0]        w_side;
    logic [IDX_W-1:0]  w_idx;
    logic              addr_ok;
    logic              entry_ok;
    logic              write_ok;

    logic [N_OUT-1:0]  mux_out;
    logic [N_OUT-1:0]  mux_oe;
    logic [N_OUT-1:0]  route_out;
    logic [N_OUT-1:0]  route_oe;

    assign cfg_ready = (state == IDLE) & ~rst;
    assign accept    = cfg_valid & cfg_ready;
    assign w_side    = cfg_wdata[2:0];
    assign w_idx     = cfg_wdata[ENT_W-1:3];
    assign addr_ok   = (32'(cfg_addr) < N_OUT);
    assign write_ok  = addr_ok & entry_ok;

    // An entry is storable only if its index exists on the named side
    always_comb begin
        entry_ok = 1'b0;
        case (w_side)
            SIDE_OFF:                entry_ok = 1'b1;
            SIDE_TOP, SIDE_BOTTOM:   entry_ok = (32'(w_idx) < W_TB);
            SIDE_RIGHT, SIDE_LEFT:   entry_ok = (32'(w_idx) < W_LR);
            default:                 entry_ok = 1'b0;
        endcase
    end

    // Configuration controller: command decode, shadow/active storage and
    // the CLEAR sweep, which zeroes one shadow entry per cycle and leaves
    // the active routing alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            clr_addr   <= '0;
            cfg_rdata  <= '0;
            cfg_rvalid <= 1'b0;
            cfg_done   <= 1'b0;
            cfg_err    <= 1'b0;
            for (int i = 0; i < N_OUT; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            cfg_rvalid <= 1'b0;
            cfg_done   <= 1'b0;
            cfg_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (cfg_op)
                            OP_WRITE: begin
                                if (write_ok) begin
                                    shadow[cfg_addr] <= cfg_wdata;
                                end else begin
                                    cfg_err <= 1'b1;
                                end
                            end
                            OP_COMMIT: begin
                                for (int i = 0; i < N_OUT; i++) begin
                                    active[i] <= shadow[i];
                                end
                                cfg_done <= 1'b1;
                            end
                            OP_CLEAR: begin
                                state    <= CLEAR;
                                clr_addr <= '0;
                            end
                            OP_READ: begin
                                if (addr_ok) begin
                                    cfg_rdata  <= shadow[cfg_addr];
                                    cfg_rvalid <= 1'b1;
                                end else begin
                                    cfg_rdata <= '0;
                                    cfg_err   <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                CLEAR: begin
                    shadow[clr_addr] <= '0;
                    if (clr_addr == LAST_ADDR) begin
                        state    <= IDLE;
                        cfg_done <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // One selector per output wire, fed only from the active store
    for (genvar o = 0; o < N_OUT; o++) begin : g_mux
        sb_route_mux #(
            .W_TB  (W_TB),
            .W_LR  (W_LR),
            .IDX_W (IDX_W)
        ) u_mux (
            .entry     (active[o]),
            .in_top    (in_top),
            .in_right  (in_right),
            .in_bottom (in_bottom),
            .in_left   (in_left),
            .out       (mux_out[o]),
            .oe        (mux_oe[o])
        );
    end

    // Optional output register adds exactly one cycle of latency
    if (REG_OUT) begin : g_reg_out
        logic [N_OUT-1:0] out_q;
        logic [N_OUT-1:0] oe_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                out_q <= '0;
                oe_q  <= '0;
            end else begin
                out_q <= mux_out;
                oe_q  <= mux_oe;
            end
        end

        assign route_out = out_q;
        assign route_oe  = oe_q;
    end else begin : g_comb_out
        assign route_out = mux_out;
        assign route_oe  = mux_oe;
    end

    assign out_top    = route_out[RIGHT0-1:0];
    assign oe_top     = route_oe[RIGHT0-1:0];
    assign out_right  = route_out[BOTTOM0-1:RIGHT0];
    assign oe_right   = route_oe[BOTTOM0-1:RIGHT0];
    assign out_bottom = route_out[LEFT0-1:BOTTOM0];
    assign oe_bottom  = route_oe[LEFT0-1:BOTTOM0];
    assign out_left   = route_out[N_OUT-1:LEFT0];
    assign oe_left    = route_oe[N_OUT-1:LEFT0];

endmodule
